// File: rtl/hazard_forward_unit_if.sv
// ID-stage side of the hazard unit: instruction fields in, stall/forward selects out.
// master = ID stage driving the operands, slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int CNTW  = 16
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic            id_valid;
    logic [AW-1:0]   id_rs;
    logic [AW-1:0]   id_rt;
    logic            id_rt_used;
    logic [AW-1:0]   id_rd;
    logic            id_we;
    logic            id_is_load;
    logic            flush;
    logic            stall;
    logic [SELW-1:0] fwd_sel_a;
    logic [SELW-1:0] fwd_sel_b;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_rd, id_we, id_is_load, flush,
        input  stall, fwd_sel_a, fwd_sel_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_rd, id_we, id_is_load, flush,
        output stall, fwd_sel_a, fwd_sel_b, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Data-hazard unit beside ID: shift scoreboard of in-flight producers, operand
// forwarding selects for rs/rt, load-use stall request and a saturating stall counter.
module hazard_forward_unit #(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNTW       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_forward_unit_if.slave  hz
);
    localparam int SELW = $clog2(DEPTH + 1);

    // Index 0 is E1 (youngest producer), index DEPTH-1 the oldest tracked.
    logic [DEPTH-1:0] ent_v;
    logic [DEPTH-1:0] ent_we;
    logic [DEPTH-1:0] ent_ld;
    logic [AW-1:0]    ent_rd [DEPTH];
    logic [CNTW-1:0]  cnt_q;

    logic [SELW-1:0]  hit_a;
    logic [SELW-1:0]  hit_b;
    logic             luse_a;
    logic             luse_b;
    logic             stall_int;
    logic             bubble;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        hit_a  = '0;
        hit_b  = '0;
        luse_a = 1'b0;
        luse_b = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_v[k] && ent_we[k] && (ent_rd[k] == hz.id_rs) && (hz.id_rs != '0)) begin
                hit_a  = SELW'(k + 1);
                luse_a = ent_ld[k] && ((k + 1) < LOAD_STAGE);
            end
            if (ent_v[k] && ent_we[k] && (ent_rd[k] == hz.id_rt) && (hz.id_rt != '0)) begin
                hit_b  = SELW'(k + 1);
                luse_b = ent_ld[k] && ((k + 1) < LOAD_STAGE);
            end
        end
    end

    // Flush overrides any load-use request: the squashed instruction needs no operands.
    always_comb begin
        stall_int = hz.id_valid && !hz.flush && (luse_a || (hz.id_rt_used && luse_b));
        bubble    = stall_int || hz.flush || !hz.id_valid;
    end

    assign hz.stall     = stall_int;
    assign hz.fwd_sel_a = stall_int ? '0 : hit_a;
    assign hz.fwd_sel_b = (stall_int || !hz.id_rt_used) ? '0 : hit_b;
    assign hz.stall_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_v  <= '0;
            ent_we <= '0;
            ent_ld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_rd[k] <= '0;
            end
            cnt_q  <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_v[k]  <= ent_v[k-1];
                ent_we[k] <= ent_we[k-1];
                ent_ld[k] <= ent_ld[k-1];
                ent_rd[k] <= ent_rd[k-1];
            end
            if (bubble) begin
                ent_v[0]  <= 1'b0;
                ent_we[0] <= 1'b0;
                ent_ld[0] <= 1'b0;
                ent_rd[0] <= '0;
            end else begin
                // Writes to r0 are dropped at entry so they can never be forwarded.
                ent_v[0]  <= 1'b1;
                ent_we[0] <= hz.id_we && (hz.id_rd != '0);
                ent_ld[0] <= hz.id_is_load;
                ent_rd[0] <= hz.id_rd;
            end
            if (stall_int && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model; a CNTW=2 instance covers saturation.
module tb_hazard_forward_unit;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LS    = 2;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] rd;
        logic          ld;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = '0;
    logic [AW-1:0] id_rt = '0;
    logic          id_rt_used = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_we = 1'b0;
    logic          id_is_load = 1'b0;
    logic          flush = 1'b0;
    logic          chk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    entry_t mq[$];
    int     m_cnt0 = 0;
    int     m_cnt1 = 0;

    always #5 clk = ~clk;

    hazard_forward_unit_if #(.AW(AW), .DEPTH(DEPTH), .CNTW(16)) if0 ();
    hazard_forward_unit_if #(.AW(AW), .DEPTH(DEPTH), .CNTW(2))  if1 ();

    assign if0.id_valid = id_valid;    assign if1.id_valid = id_valid;
    assign if0.id_rs = id_rs;          assign if1.id_rs = id_rs;
    assign if0.id_rt = id_rt;          assign if1.id_rt = id_rt;
    assign if0.id_rt_used = id_rt_used; assign if1.id_rt_used = id_rt_used;
    assign if0.id_rd = id_rd;          assign if1.id_rd = id_rd;
    assign if0.id_we = id_we;          assign if1.id_we = id_we;
    assign if0.id_is_load = id_is_load; assign if1.id_is_load = id_is_load;
    assign if0.flush = flush;          assign if1.flush = flush;

    hazard_forward_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LS), .CNTW(16)) dut0 (
        .clk(clk), .reset(reset), .hz(if0)
    );
    hazard_forward_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LS), .CNTW(2)) dut1 (
        .clk(clk), .reset(reset), .hz(if1)
    );

    function automatic int m_hit(logic [AW-1:0] src);
        if (src == 0) return 0;
        for (int k = 0; k < mq.size(); k++)
            if (mq[k].v && mq[k].we && mq[k].rd == src) return k + 1;
        return 0;
    endfunction

    function automatic bit m_luse(logic [AW-1:0] src);
        int h;
        h = m_hit(src);
        return (h != 0) && mq[h-1].ld && (h < LS);
    endfunction

    function automatic bit m_stall();
        return id_valid && !flush && (m_luse(id_rs) || (id_rt_used && m_luse(id_rt)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        entry_t e;
        bit st;
        if (reset) begin
            mq.delete();
            repeat (DEPTH) mq.push_back('0);
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            st = m_stall();
            if (st && m_cnt0 < 65535) m_cnt0++;
            if (st && m_cnt1 < 3) m_cnt1++;
            e = '0;
            if (id_valid && !flush && !st) begin
                e.v  = 1'b1;
                e.we = id_we && (id_rd != 0);
                e.rd = id_rd;
                e.ld = id_is_load;
            end
            mq.push_front(e);
            mq.delete(mq.size() - 1);
        end
    end

    always @(negedge clk) begin
        bit st;
        int ea, eb;
        if (!reset && chk_en) begin
            st = m_stall();
            ea = st ? 0 : m_hit(id_rs);
            eb = (st || !id_rt_used) ? 0 : m_hit(id_rt);
            check("model_stall0", 32'(if0.stall), 32'(st));
            check("model_sel_a0", 32'(if0.fwd_sel_a), 32'(ea));
            check("model_sel_b0", 32'(if0.fwd_sel_b), 32'(eb));
            check("model_cnt0", 32'(if0.stall_cnt), 32'(m_cnt0));
            check("model_stall1", 32'(if1.stall), 32'(st));
            check("model_sel_a1", 32'(if1.fwd_sel_a), 32'(ea));
            check("model_sel_b1", 32'(if1.fwd_sel_b), 32'(eb));
            check("model_cnt1", 32'(if1.stall_cnt), 32'(m_cnt1));
        end
    end

    task automatic issue(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic ru, input logic [AW-1:0] rd, input logic we,
                         input logic ld, input logic fl);
        @(posedge clk); #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_rt_used = ru;
        id_rd = rd; id_we = we; id_is_load = ld; flush = fl;
        @(negedge clk);
    endtask

    task automatic nop();                       issue(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input logic [AW-1:0] rd); issue(1, 0, 0, 0, rd, 1, 0, 0); endtask
    task automatic ld_op(input logic [AW-1:0] rd); issue(1, 0, 0, 0, rd, 1, 1, 0); endtask
    task automatic rdr(input logic [AW-1:0] rs); issue(1, rs, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_stall", 32'(if0.stall), 0);
        check("reset_cnt", 32'(if0.stall_cnt), 0);

        // ALU chain: forwarding source ages from E1 to E3, then drops off
        alu(3);
        rdr(3); check("chain_e1", 32'(if0.fwd_sel_a), 1);
        rdr(3); check("chain_e2", 32'(if0.fwd_sel_a), 2);
        rdr(3); check("chain_e3", 32'(if0.fwd_sel_a), 3);
        rdr(3); check("chain_gone", 32'(if0.fwd_sel_a), 0);

        // Youngest producer wins
        alu(4); nop(); alu(4);
        rdr(4); check("priority", 32'(if0.fwd_sel_a), 1);

        // Load-use: one stall cycle, then forward from E2
        ld_op(5);
        rdr(5); check("luse_stall", 32'(if0.stall), 1);
                check("luse_sel_during", 32'(if0.fwd_sel_a), 0);
        rdr(5); check("luse_release", 32'(if0.stall), 0);
                check("luse_sel_e2", 32'(if0.fwd_sel_a), 2);
                check("luse_cnt", 32'(if0.stall_cnt), 1);

        // r0 suppression and rt_used gating
        alu(0);
        rdr(0); check("r0_sel_a", 32'(if0.fwd_sel_a), 0);
        alu(6);
        issue(1, 0, 6, 0, 0, 0, 0, 0); check("rt_unused_sel_b", 32'(if0.fwd_sel_b), 0);
                                        check("rt_unused_stall", 32'(if0.stall), 0);
        issue(1, 0, 6, 1, 0, 0, 0, 0); check("rt_used_sel_b", 32'(if0.fwd_sel_b), 2);

        // Flush squashes the producer; flush beats a load-use stall
        issue(1, 0, 0, 0, 7, 1, 0, 1);
        rdr(7); check("flush_prod", 32'(if0.fwd_sel_a), 0);
        ld_op(8);
        issue(1, 8, 0, 0, 0, 0, 0, 1); check("flush_stall", 32'(if0.stall), 0);

        // Reset mid-operation
        alu(9); alu(10); alu(11);
        @(posedge clk); #1;
        reset = 1'b1; id_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        id_valid = 1'b1; id_rs = 11; id_rt = 10; id_rt_used = 1'b1;
        id_rd = 0; id_we = 1'b0; id_is_load = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(if0.stall), 0);
        check("rst_sel_a", 32'(if0.fwd_sel_a), 0);
        check("rst_sel_b", 32'(if0.fwd_sel_b), 0);
        check("rst_cnt", 32'(if0.stall_cnt), 0);

        // Five load-use stalls: narrow counter sticks at 3
        repeat (5) begin
            ld_op(12); rdr(12); rdr(12);
        end
        check("sat_cnt_narrow", 32'(if1.stall_cnt), 3);
        check("sat_cnt_wide", 32'(if0.stall_cnt), 5);

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset      = ($urandom_range(0, 149) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs      = AW'($urandom_range(0, 7));
            id_rt      = AW'($urandom_range(0, 7));
            id_rt_used = $urandom_range(0, 1);
            id_rd      = AW'($urandom_range(0, 7));
            id_we      = ($urandom_range(0, 3) != 0);
            id_is_load = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
